// File: rtl/multiplier_arbiter_pkg.sv
// Purpose: shared defaults for the multiplier arbiter and its multiplier primitive.
// Latency: n/a (constants only).
// Backpressure: n/a.
package multiplier_arbiter_pkg;

   // Default requester count and operand widths.
   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_DATA_WIDTH_1 = 8;
   localparam int DEF_DATA_WIDTH_2 = 8;

   // Register stages inside the multiplier. The arbiter sizes its tag
   // pipeline from this same value, so products and tags stay aligned.
   localparam int DEF_MULT_LATENCY = 1;

endpackage

// File: rtl/multiplier_arbiter_multiplier.sv
// Purpose: unsigned full-precision multiplier with LATENCY register stages.
// Latency: LATENCY cycles from a/b to p.
// Backpressure: none; accepts one operand pair every cycle.
module multiplier_arbiter_multiplier
   import multiplier_arbiter_pkg::*;
#(
   parameter int A_WIDTH = DEF_DATA_WIDTH_1,
   parameter int B_WIDTH = DEF_DATA_WIDTH_2,
   parameter int LATENCY = DEF_MULT_LATENCY
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [A_WIDTH-1:0]         a,
   input  logic [B_WIDTH-1:0]         b,
   output logic [A_WIDTH+B_WIDTH-1:0] p
);

   localparam int PW = A_WIDTH + B_WIDTH;

   logic [PW-1:0] stage [LATENCY];

   // Multiply into the first stage, then shift through the remaining stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= PW'(a) * PW'(b);
         for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
   end

   assign p = stage[LATENCY-1];

endmodule

// File: rtl/multiplier_arbiter.sv
// Purpose: round-robin share of one multiplier among NUM_REQ requesters, products tagged with requester ID.
// Latency: grant in cycle t gives res_valid_o in cycle t+1+MULT_LATENCY.
// Backpressure: none on results; requesters see grant_o as consumption, en_i low stalls all grants.
module multiplier_arbiter
   import multiplier_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int DATA_WIDTH_1 = DEF_DATA_WIDTH_1,
   parameter int DATA_WIDTH_2 = DEF_DATA_WIDTH_2,
   parameter int MULT_LATENCY = DEF_MULT_LATENCY,
   parameter int ID_WIDTH     = $clog2(NUM_REQ)
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en_i,
   input  logic [NUM_REQ-1:0]                 req_i,
   input  logic [NUM_REQ*DATA_WIDTH_1-1:0]    data1_i,
   input  logic [NUM_REQ*DATA_WIDTH_2-1:0]    data2_i,
   output logic [NUM_REQ-1:0]                 grant_o,
   output logic                               res_valid_o,
   output logic [ID_WIDTH-1:0]                res_id_o,
   output logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] data_o
);

   localparam int PW = DATA_WIDTH_1 + DATA_WIDTH_2;

   logic [ID_WIDTH-1:0]     ptr;
   logic [ID_WIDTH-1:0]     win;
   logic                    found;
   logic [NUM_REQ-1:0]      cand;
   logic [DATA_WIDTH_1-1:0] op1;
   logic [DATA_WIDTH_2-1:0] op2;
   logic [MULT_LATENCY:0]   v;
   logic [ID_WIDTH-1:0]     id [MULT_LATENCY+1];
   logic [PW-1:0]           prod;

   // Reset also masks candidates so grant_o reads zero while rst is high.
   assign cand = (en_i && !rst) ? req_i : '0;

   // Round-robin search: first candidate at or above ptr, wrapping modulo NUM_REQ.
   always_comb begin : arb
      logic [ID_WIDTH:0] idx;
      found   = 1'b0;
      win     = '0;
      grant_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, ptr} + (ID_WIDTH+1)'(i);
         if (idx >= (ID_WIDTH+1)'(NUM_REQ)) idx = idx - (ID_WIDTH+1)'(NUM_REQ);
         if (!found && cand[idx[ID_WIDTH-1:0]]) begin
            found = 1'b1;
            win   = idx[ID_WIDTH-1:0];
         end
      end
      if (found) grant_o[win] = 1'b1;
   end

   // Pointer moves just past the winner; holds when nothing is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (win == ID_WIDTH'(NUM_REQ-1)) ? '0 : win + ID_WIDTH'(1);
      end
   end

   // Capture the winner's operands; they hold between grants and need no reset.
   always_ff @(posedge clk) begin
      if (found) begin
         op1 <= data1_i[int'(win)*DATA_WIDTH_1 +: DATA_WIDTH_1];
         op2 <= data2_i[int'(win)*DATA_WIDTH_2 +: DATA_WIDTH_2];
      end
   end

   // Valid/ID tags travel alongside the operands through the multiplier stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         for (int i = 0; i <= MULT_LATENCY; i++) id[i] <= '0;
      end else begin
         v[0] <= found;
         if (found) id[0] <= win;
         for (int i = 1; i <= MULT_LATENCY; i++) begin
            v[i]  <= v[i-1];
            id[i] <= id[i-1];
         end
      end
   end

   multiplier_arbiter_multiplier #(
      .A_WIDTH (DATA_WIDTH_1),
      .B_WIDTH (DATA_WIDTH_2),
      .LATENCY (MULT_LATENCY)
   ) u_mult (
      .clk (clk),
      .rst (rst),
      .a   (op1),
      .b   (op2),
      .p   (prod)
   );

   assign res_valid_o = v[MULT_LATENCY];
   assign res_id_o    = id[MULT_LATENCY];
   assign data_o      = v[MULT_LATENCY] ? prod : '0;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Purpose: directed bench for multiplier_arbiter with a result scoreboard.
// Latency: expects products two cycles after each grant.
// Backpressure: none; the monitor accepts a result every cycle.
module tb_multiplier_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_i;
   logic [3:0]  req_i;
   logic [31:0] data1_i;
   logic [31:0] data2_i;
   logic [3:0]  grant_o;
   logic        res_valid_o;
   logic [1:0]  res_id_o;
   logic [15:0] data_o;

   int checks = 0;
   int errors = 0;

   // Expected results: {id, product}
   logic [17:0] exp_q [$];

   multiplier_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en_i),
      .req_i       (req_i),
      .data1_i     (data1_i),
      .data2_i     (data2_i),
      .grant_o     (grant_o),
      .res_valid_o (res_valid_o),
      .res_id_o    (res_id_o),
      .data_o      (data_o)
   );

   always #5 clk = ~clk;

   // Monitor: compare every presented product with the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL spurious_result: got id=%0d data=%0d, required no result", res_id_o, data_o);
            end else begin
               logic [17:0] e;
               e = exp_q.pop_front();
               if (res_id_o !== e[17:16] || data_o !== e[15:0]) begin
                  errors++;
                  $display("FAIL result: got id=%0d data=%0d, required id=%0d data=%0d",
                           res_id_o, data_o, e[17:16], e[15:0]);
               end
            end
         end else begin
            checks++;
            if (data_o !== 16'd0) begin
               errors++;
               $display("FAIL idle_data: got %0d, required 0", data_o);
            end
         end
      end
   end

   task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
      data1_i[k*8 +: 8] = a;
      data2_i[k*8 +: 8] = b;
   endtask

   // Entered at posedge+1: drive inputs, check grant before the next edge,
   // record the expected product, then advance to the next posedge+1.
   task automatic step(input logic [3:0] req, input logic en, input logic [3:0] exp_g,
                       input logic [1:0] exp_id, input logic [15:0] exp_p, input bit push);
      req_i = req;
      en_i  = en;
      #3;
      checks++;
      if (grant_o !== exp_g) begin
         errors++;
         $display("FAIL grant: req=%b en=%b got %b, required %b", req, en, grant_o, exp_g);
      end
      if (push && exp_g != 4'b0000) exp_q.push_back({exp_id, exp_p});
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (grant_o !== 4'b0 || res_valid_o !== 1'b0 || res_id_o !== 2'd0 || data_o !== 16'd0) begin
         errors++;
         $display("FAIL %s: got grant=%b valid=%b id=%0d data=%0d, required all zero",
                  name, grant_o, res_valid_o, res_id_o, data_o);
      end
   endtask

   initial begin
      rst     = 1'b1;
      en_i    = 1'b1;
      req_i   = 4'b1111;
      data1_i = '0;
      data2_i = '0;
      #2;
      check_reset_outputs("reset_state");
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_outputs("reset_hold");
      req_i = 4'b0000;
      rst   = 1'b0;
      @(posedge clk);
      #1;

      // Single request: 34*22 = 748 from requester 0 (ptr -> 1)
      set_op(0, 8'd34, 8'd22);
      step(4'b0001, 1'b1, 4'b0001, 2'd0, 16'd748, 1'b1);
      step(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0, 1'b0);
      step(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0, 1'b0);

      // Rotation from ptr=1 with operands (k+1)*10 and 3
      for (int k = 0; k < 4; k++) set_op(k, 8'((k + 1) * 10), 8'd3);
      step(4'b1111, 1'b1, 4'b0010, 2'd1, 16'd60,  1'b1);
      step(4'b1111, 1'b1, 4'b0100, 2'd2, 16'd90,  1'b1);
      step(4'b1111, 1'b1, 4'b1000, 2'd3, 16'd120, 1'b1);
      step(4'b1111, 1'b1, 4'b0001, 2'd0, 16'd30,  1'b1);
      step(4'b1111, 1'b1, 4'b0010, 2'd1, 16'd60,  1'b1);
      step(4'b1111, 1'b1, 4'b0100, 2'd2, 16'd90,  1'b1);
      step(4'b1111, 1'b1, 4'b1000, 2'd3, 16'd120, 1'b1);

      // Wrap-around: after grant to 3, req 1001 -> 0 then 3 then 0
      step(4'b1001, 1'b1, 4'b0001, 2'd0, 16'd30,  1'b1);
      step(4'b1001, 1'b1, 4'b1000, 2'd3, 16'd120, 1'b1);
      step(4'b1001, 1'b1, 4'b0001, 2'd0, 16'd30,  1'b1);
      // ptr=1: grant 2 moves ptr to 3, then search wraps from 3 to 0
      step(4'b0100, 1'b1, 4'b0100, 2'd2, 16'd90,  1'b1);
      step(4'b0001, 1'b1, 4'b0001, 2'd0, 16'd30,  1'b1);

      // Enable low: a product in flight still emerges, no new grants
      step(4'b1111, 1'b1, 4'b0010, 2'd1, 16'd60, 1'b1);
      for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 4'b0000, 2'd0, 16'd0, 1'b0);

      // Full scale from requester 2 (ptr=2): 255*255 = 65025
      set_op(2, 8'd255, 8'd255);
      step(4'b0100, 1'b1, 4'b0100, 2'd2, 16'd65025, 1'b1);
      step(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0, 1'b0);
      step(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0, 1'b0);

      // Reset mid-flight: grant to 2 (ptr=3 wraps) must never produce a result
      set_op(2, 8'd7, 8'd7);
      step(4'b0100, 1'b1, 4'b0100, 2'd2, 16'd49, 1'b0);
      req_i = 4'b0000;
      rst   = 1'b1;
      #1;
      check_reset_outputs("reset_midflight");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0, 1'b0);

      // After reset ptr=0, requester 0 idle: requester 1 wins, 9*99 = 891
      set_op(1, 8'd9, 8'd99);
      step(4'b0010, 1'b1, 4'b0010, 2'd1, 16'd891, 1'b1);
      for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0, 1'b0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
